// File: rtl/gol_pkg.sv
// Shared types and address packing for the GOL cell-memory arbiter.
package gol_pkg;

    localparam int unsigned GOL_K = 6;

    typedef enum logic [1:0] {SRC_NONE, SRC_DSP, SRC_EDIT, SRC_UPD} arb_src_t;
    typedef enum logic [1:0] {ED_IDLE, ED_RD, ED_WAIT, ED_WR} edit_state_t;

    // Row-major cell address {R, C}; caller truncates to 2*k bits.
    function automatic logic [31:0] cell_addr(input logic [15:0] r, input logic [15:0] c,
                                              input int unsigned k);
        return (32'(r) << k) | 32'(c);
    endfunction

endpackage

// File: rtl/gol_edit_rmw.sv
// Cursor edit sequencer: accepts a toggle in EDIT mode, then reads the cell and writes back its inverse.
module gol_edit_rmw
    import gol_pkg::*;
#(
    parameter int unsigned K = GOL_K
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run_mode_i,
    input  logic         toggle_i,
    input  logic [K-1:0] curs_r_i,
    input  logic [K-1:0] curs_c_i,
    input  logic         gnt_i,
    input  logic         rdata_i,
    output logic         ram_req_c_o,
    output logic         ram_we_c_o,
    output logic [K-1:0] addr_r_o,
    output logic [K-1:0] addr_c_o,
    output logic         wdata_o,
    output logic         busy_o,
    output logic         hold_c_o,
    output logic         done_c_o
);

    edit_state_t  state_q, state_d;
    logic         pending_q, pending_d;
    logic [K-1:0] addr_r_q, addr_r_d;
    logic [K-1:0] addr_c_q, addr_c_d;
    logic         wdata_q, wdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ED_IDLE;
            pending_q <= 1'b0;
            addr_r_q  <= '0;
            addr_c_q  <= '0;
            wdata_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_r_q  <= addr_r_d;
            addr_c_q  <= addr_c_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        addr_r_d    = addr_r_q;
        addr_c_d    = addr_c_q;
        wdata_d     = wdata_q;
        ram_req_c_o = 1'b0;
        ram_we_c_o  = 1'b0;
        hold_c_o    = 1'b0;
        done_c_o    = 1'b0;

        // Pending stays set for the whole RMW, so the latched cursor cannot move mid-edit.
        if (toggle_i && !run_mode_i && !pending_q) begin
            pending_d = 1'b1;
            addr_r_d  = curs_r_i;
            addr_c_d  = curs_c_i;
        end

        unique case (state_q)
            ED_IDLE: begin
                if (pending_q) state_d = ED_RD;
            end
            ED_RD: begin
                ram_req_c_o = 1'b1;
                if (gnt_i) state_d = ED_WAIT;
            end
            ED_WAIT: begin
                hold_c_o = 1'b1;
                wdata_d  = ~rdata_i;
                state_d  = ED_WR;
            end
            ED_WR: begin
                hold_c_o    = 1'b1;
                ram_req_c_o = 1'b1;
                ram_we_c_o  = 1'b1;
                if (gnt_i) begin
                    done_c_o  = 1'b1;
                    pending_d = 1'b0;
                    state_d   = ED_IDLE;
                end
            end
            default: state_d = ED_IDLE;
        endcase
    end

    assign addr_r_o = addr_r_q;
    assign addr_c_o = addr_c_q;
    assign wdata_o  = wdata_q;
    assign busy_o   = pending_q;

endmodule

// File: rtl/gol_cell_arbiter.sv
// Single-port GOL cell RAM arbiter: display > edit RMW > update engine, with tagged read return.
// Define GOL_ARB_STALL_CNT_EN to add the saturating upd_stall_cnt output.
module gol_cell_arbiter
    import gol_pkg::*;
#(
    parameter int unsigned K = GOL_K
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run_mode,
    input  logic           dsp_read_en,
    input  logic [K-1:0]   dsp_addrR,
    input  logic [K-1:0]   dsp_addrC,
    output logic           dsp_valid,
    output logic           dsp_cell_state,
    input  logic           edit_toggle,
    input  logic [K-1:0]   curs_R,
    input  logic [K-1:0]   curs_C,
    output logic           edit_busy,
    output logic           edit_done,
    input  logic           upd_req,
    input  logic           upd_we,
    input  logic [K-1:0]   upd_addrR,
    input  logic [K-1:0]   upd_addrC,
    input  logic           upd_wdata,
    output logic           upd_gnt,
    output logic           upd_rvalid,
    output logic           upd_rdata,
`ifdef GOL_ARB_STALL_CNT_EN
    output logic [15:0]    upd_stall_cnt,
`endif
    output logic           mem_en,
    output logic           mem_we,
    output logic [2*K-1:0] mem_addr,
    output logic           mem_wdata,
    input  logic           mem_rdata
);

    localparam int unsigned AW = 2 * K;

    logic         dsp_gnt_c, ed_gnt_c;
    logic         ed_req_c, ed_we_c, ed_hold_c, ed_done_c;
    logic         ed_wdata, ed_busy;
    logic [K-1:0] ed_addr_r, ed_addr_c;
    arb_src_t     src_q, src_d;
    logic         dsp_data_q, upd_data_q;

    gol_edit_rmw #(.K(K)) u_edit (
        .clk         (clk),
        .rst         (rst),
        .run_mode_i  (run_mode),
        .toggle_i    (edit_toggle),
        .curs_r_i    (curs_R),
        .curs_c_i    (curs_C),
        .gnt_i       (ed_gnt_c),
        .rdata_i     (mem_rdata),
        .ram_req_c_o (ed_req_c),
        .ram_we_c_o  (ed_we_c),
        .addr_r_o    (ed_addr_r),
        .addr_c_o    (ed_addr_c),
        .wdata_o     (ed_wdata),
        .busy_o      (ed_busy),
        .hold_c_o    (ed_hold_c),
        .done_c_o    (ed_done_c)
    );

    // Grants are gated by rst so the RAM sees no access while reset is asserted.
    always_comb begin
        dsp_gnt_c = !rst && dsp_read_en;
        ed_gnt_c  = !rst && !dsp_read_en && ed_req_c;
        upd_gnt   = !rst && upd_req && !dsp_read_en && !ed_req_c && !ed_hold_c;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 1'b0;
        src_d     = SRC_NONE;
        if (dsp_gnt_c) begin
            mem_en   = 1'b1;
            mem_addr = AW'(cell_addr(16'(dsp_addrR), 16'(dsp_addrC), K));
            src_d    = SRC_DSP;
        end else if (ed_gnt_c) begin
            mem_en    = 1'b1;
            mem_we    = ed_we_c;
            mem_addr  = AW'(cell_addr(16'(ed_addr_r), 16'(ed_addr_c), K));
            mem_wdata = ed_wdata;
            src_d     = ed_we_c ? SRC_NONE : SRC_EDIT;
        end else if (upd_gnt) begin
            mem_en    = 1'b1;
            mem_we    = upd_we;
            mem_addr  = AW'(cell_addr(16'(upd_addrR), 16'(upd_addrC), K));
            mem_wdata = upd_wdata;
            src_d     = upd_we ? SRC_NONE : SRC_UPD;
        end
    end

    // Source tag steers next-cycle read data; per-requester copies hold the last returned value.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q      <= SRC_NONE;
            dsp_data_q <= 1'b0;
            upd_data_q <= 1'b0;
        end else begin
            src_q <= src_d;
            if (src_q == SRC_DSP) dsp_data_q <= mem_rdata;
            if (src_q == SRC_UPD) upd_data_q <= mem_rdata;
        end
    end

    assign dsp_valid      = (src_q == SRC_DSP);
    assign dsp_cell_state = dsp_valid ? mem_rdata : dsp_data_q;
    assign upd_rvalid     = (src_q == SRC_UPD);
    assign upd_rdata      = upd_rvalid ? mem_rdata : upd_data_q;
    assign edit_busy      = ed_busy;
    assign edit_done      = ed_done_c;

`ifdef GOL_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (upd_req && !upd_gnt && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign upd_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gol_cell_arbiter.sv
// Directed bench for gol_cell_arbiter with a 1-cycle-latency RAM model.
module tb_gol_cell_arbiter;

    localparam int unsigned K = 6;

    logic         clk = 1'b0;
    logic         rst, run_mode;
    logic         dsp_read_en;
    logic [K-1:0] dsp_addrR, dsp_addrC;
    logic         dsp_valid, dsp_cell_state;
    logic         edit_toggle;
    logic [K-1:0] curs_R, curs_C;
    logic         edit_busy, edit_done;
    logic         upd_req, upd_we, upd_wdata;
    logic [K-1:0] upd_addrR, upd_addrC;
    logic         upd_gnt, upd_rvalid, upd_rdata;
`ifdef GOL_ARB_STALL_CNT_EN
    logic [15:0]  upd_stall_cnt;
`endif
    logic         mem_en, mem_we, mem_wdata, mem_rdata;
    logic [11:0]  mem_addr;

    gol_cell_arbiter #(.K(K)) dut (
        .clk            (clk),
        .rst            (rst),
        .run_mode       (run_mode),
        .dsp_read_en    (dsp_read_en),
        .dsp_addrR      (dsp_addrR),
        .dsp_addrC      (dsp_addrC),
        .dsp_valid      (dsp_valid),
        .dsp_cell_state (dsp_cell_state),
        .edit_toggle    (edit_toggle),
        .curs_R         (curs_R),
        .curs_C         (curs_C),
        .edit_busy      (edit_busy),
        .edit_done      (edit_done),
        .upd_req        (upd_req),
        .upd_we         (upd_we),
        .upd_addrR      (upd_addrR),
        .upd_addrC      (upd_addrC),
        .upd_wdata      (upd_wdata),
        .upd_gnt        (upd_gnt),
        .upd_rvalid     (upd_rvalid),
        .upd_rdata      (upd_rdata),
`ifdef GOL_ARB_STALL_CNT_EN
        .upd_stall_cnt  (upd_stall_cnt),
`endif
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: read-first, 1-cycle read latency; pk_* preloads cells from the bench.
    logic        ram [0:4095];
    logic        pk_we = 1'b0;
    logic [11:0] pk_a  = 12'h000;
    logic        pk_d  = 1'b0;
    int          n_wr;

    always @(posedge clk) begin
        if (pk_we) begin
            ram[pk_a] <= pk_d;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
        if (mem_en && mem_we) n_wr <= n_wr + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic d);
        pk_we = 1'b1;
        pk_a  = a;
        pk_d  = d;
        tick();
        pk_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          w0;
        logic [4:0]  t3_en, t3_we, t3_done, t3_busy;
        logic [8:0]  t4_dsp, t4_en, t4_we, t4_gnt, t4_done;

        rst = 1'b1; run_mode = 1'b0; dsp_read_en = 1'b0; dsp_addrR = '0; dsp_addrC = '0;
        edit_toggle = 1'b0; curs_R = '0; curs_C = '0;
        upd_req = 1'b0; upd_we = 1'b0; upd_addrR = '0; upd_addrC = '0; upd_wdata = 1'b0;

        poke(12'h0C5, 1'b1); poke(12'h041, 1'b1); poke(12'h000, 1'b0); poke(12'h042, 1'b0);
        poke(12'h082, 1'b0); poke(12'h1C7, 1'b1); poke(12'h294, 1'b0); poke(12'h083, 1'b0);

        // Reset: no RAM access even with a display request pending
        dsp_read_en = 1'b1; #1;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        dsp_read_en = 1'b0;
        tick();
        rst = 1'b0; #1;
        check("rst_dsp_valid", 32'(dsp_valid), 32'd0);
        check("rst_dsp_state", 32'(dsp_cell_state), 32'd0);
        check("rst_edit_busy", 32'(edit_busy), 32'd0);
        check("rst_edit_done", 32'(edit_done), 32'd0);
        check("rst_upd_gnt", 32'(upd_gnt), 32'd0);
        check("rst_upd_rvalid", 32'(upd_rvalid), 32'd0);
        check("rst_upd_rdata", 32'(upd_rdata), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);

        // 1: display read of (3,5)
        dsp_read_en = 1'b1; dsp_addrR = 6'd3; dsp_addrC = 6'd5; #1;
        check("t1_addr", 32'(mem_addr), 32'h0C5);
        check("t1_en", 32'(mem_en), 32'd1);
        check("t1_we", 32'(mem_we), 32'd0);
        tick();
        dsp_read_en = 1'b0; #1;
        check("t1_valid", 32'(dsp_valid), 32'd1);
        check("t1_state", 32'(dsp_cell_state), 32'd1);
        tick();
        check("t1_valid_off", 32'(dsp_valid), 32'd0);
        check("t1_hold", 32'(dsp_cell_state), 32'd1);

        // 2: display blocks update reads for 4 cycles
        dsp_read_en = 1'b1; dsp_addrR = 6'd0; dsp_addrC = 6'd0;
        upd_req = 1'b1; upd_we = 1'b0; upd_addrR = 6'd1; upd_addrC = 6'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_upd_blocked", 32'(upd_gnt), 32'd0);
            tick();
        end
        dsp_read_en = 1'b0; #1;
        check("t2_upd_gnt", 32'(upd_gnt), 32'd1);
        check("t2_upd_addr", 32'(mem_addr), 32'h041);
        check("t2_dsp_valid", 32'(dsp_valid), 32'd1);
        check("t2_dsp_state", 32'(dsp_cell_state), 32'd0);
        tick();
        upd_req = 1'b0; #1;
        check("t2_rvalid", 32'(upd_rvalid), 32'd1);
        check("t2_rdata", 32'(upd_rdata), 32'd1);
        check("t2_dsp_off", 32'(dsp_valid), 32'd0);

        // 3: edit at (10,20) on an idle bus
        run_mode = 1'b0; curs_R = 6'd10; curs_C = 6'd20; w0 = n_wr;
        t3_en = 5'b10100; t3_we = 5'b10000; t3_done = 5'b10000; t3_busy = 5'b11110;
        for (int i = 0; i < 5; i++) begin
            edit_toggle = (i == 0); #1;
            check("t3_en", 32'(mem_en), 32'(t3_en[i]));
            check("t3_we", 32'(mem_we), 32'(t3_we[i]));
            check("t3_done", 32'(edit_done), 32'(t3_done[i]));
            check("t3_busy", 32'(edit_busy), 32'(t3_busy[i]));
            if (t3_en[i]) check("t3_addr", 32'(mem_addr), 32'h294);
            if (t3_we[i]) check("t3_wdata", 32'(mem_wdata), 32'd1);
            tick();
        end
        edit_toggle = 1'b0; #1;
        check("t3_ram", 32'(ram[12'h294]), 32'd1);
        check("t3_busy_end", 32'(edit_busy), 32'd0);
        check("t3_nwr", 32'(n_wr - w0), 32'd1);

        // 4: edit at (7,7) preempted by display; update write blocked until edit write done
        curs_R = 6'd7; curs_C = 6'd7; w0 = n_wr;
        upd_we = 1'b1; upd_addrR = 6'd2; upd_addrC = 6'd2; upd_wdata = 1'b1;
        t4_dsp = 9'b000011100; t4_en = 9'b110111100; t4_we = 9'b110000000;
        t4_gnt = 9'b100000000; t4_done = 9'b010000000;
        for (int i = 0; i < 9; i++) begin
            edit_toggle = (i == 0);
            dsp_read_en = t4_dsp[i];
            upd_req     = (i >= 2);
            #1;
            check("t4_en", 32'(mem_en), 32'(t4_en[i]));
            check("t4_we", 32'(mem_we), 32'(t4_we[i]));
            check("t4_upd_gnt", 32'(upd_gnt), 32'(t4_gnt[i]));
            check("t4_done", 32'(edit_done), 32'(t4_done[i]));
            if (i == 5 || i == 7) check("t4_ed_addr", 32'(mem_addr), 32'h1C7);
            if (i == 8) check("t4_upd_addr", 32'(mem_addr), 32'h082);
            tick();
        end
        edit_toggle = 1'b0; dsp_read_en = 1'b0; upd_req = 1'b0; #1;
        check("t4_ram_edit", 32'(ram[12'h1C7]), 32'd0);
        check("t4_ram_upd", 32'(ram[12'h082]), 32'd1);
        check("t4_nwr", 32'(n_wr - w0), 32'd2);

        // 5a: toggle in run mode is dropped
        run_mode = 1'b1; curs_R = 6'd1; curs_C = 6'd1; w0 = n_wr;
        for (int i = 0; i < 6; i++) begin
            edit_toggle = (i == 0);
            tick();
        end
        edit_toggle = 1'b0; #1;
        check("t5_run_busy", 32'(edit_busy), 32'd0);
        check("t5_run_nwr", 32'(n_wr - w0), 32'd0);

        // 5b: second toggle while busy dropped; run_mode rising mid-edit does not abort
        run_mode = 1'b0; w0 = n_wr;
        for (int i = 0; i < 6; i++) begin
            edit_toggle = (i <= 1);
            if (i == 1) begin curs_R = 6'd1; curs_C = 6'd2; end
            if (i == 2) run_mode = 1'b1;
            #1;
            if (i == 1) check("t5_busy", 32'(edit_busy), 32'd1);
            if (i == 4) check("t5_done", 32'(edit_done), 32'd1);
            tick();
        end
        edit_toggle = 1'b0; run_mode = 1'b0; #1;
        check("t5_ram_041", 32'(ram[12'h041]), 32'd0);
        check("t5_ram_042", 32'(ram[12'h042]), 32'd0);
        check("t5_nwr", 32'(n_wr - w0), 32'd1);
        check("t5_busy_end", 32'(edit_busy), 32'd0);

        // 6: reset in ED_WAIT abandons the edit
        curs_R = 6'd2; curs_C = 6'd3; w0 = n_wr;
        for (int i = 0; i < 3; i++) begin
            edit_toggle = (i == 0); #1;
            if (i == 2) check("t6_rd_addr", 32'(mem_addr), 32'h083);
            tick();
        end
        edit_toggle = 1'b0; rst = 1'b1; #1;
        check("t6_rst_we", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0; #1;
        check("t6_busy", 32'(edit_busy), 32'd0);
        check("t6_en", 32'(mem_en), 32'd0);
        tick(); tick(); tick();
        check("t6_nwr", 32'(n_wr - w0), 32'd0);
        check("t6_ram", 32'(ram[12'h083]), 32'd0);

`ifdef GOL_ARB_STALL_CNT_EN
        dsp_read_en = 1'b1; upd_req = 1'b1; upd_we = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        dsp_read_en = 1'b0; upd_req = 1'b0; #1;
        check("t6_stall_cnt", 32'(upd_stall_cnt), 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
